starfield_ctrl: RTL

- Sequencer and compositor for three starfield layer instances (layer 0 nearest, layer 2 farthest).
- Generates per-layer enable and reset so the layers stay aligned to the frame.
- Applies run, pause, restart and layer-mask commands only at frame boundaries.
- Merges the layer outputs into one registered star pixel for the display pipeline.

---
 rtl/starfield_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/starfield_ctrl.sv
// starfield_ctrl: frame-aligned sequencer and compositor
// for three starfield layers (0 nearest, 2 farthest).
module starfield_ctrl #(
  parameter int         SHIFT1   = 1,
  parameter int         SHIFT2   = 2,
  parameter logic [2:0] MASK_RST = 3'b111
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_en,
  input  logic        frame_start,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [2:0]  cmd_data,
  input  logic [2:0]  sf_on,
  input  logic [23:0] sf_star,
  output logic [2:0]  sf_en,
  output logic [2:0]  sf_rst,
  output logic [1:0]  state_o,
  output logic        star_on,
  output logic [7:0]  star
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_RUN  = 2'd0,
    OP_PAU  = 2'd1,
    OP_RST  = 2'd2,
    OP_MASK = 2'd3
  } op_t;

  state_t     r_state;
  logic       r_pend;
  op_t        r_op;
  logic [2:0] r_data;
  logic [2:0] r_mask;
  logic       r_star_on;
  logic [7:0] r_star;

  logic       w_exec;
  logic       w_do_run;
  logic       w_do_pau;
  logic       w_do_rst;
  logic       w_live;
  logic       w_accept;
  logic [2:0] w_cand;
  logic       w_on;
  logic [7:0] w_pix;

  // a pending command only fires on a frame_start after its accept
  assign w_exec   = r_pend & frame_start;
  assign w_do_run = w_exec & (r_op == OP_RUN);
  assign w_do_pau = w_exec & (r_op == OP_PAU);
  assign w_do_rst = w_exec & (r_op == OP_RST);

  // layers count this pixel only when effectively running now
  assign w_live =
    ((r_state == S_RUN) & ~w_do_pau & ~w_do_rst) |
    ((r_state == S_PAUSE) & w_do_run);

  assign cmd_ready = (r_state != S_IDLE) & ~r_pend;
  assign w_accept  = cmd_valid & cmd_ready;

  assign sf_en   = {3{pix_en & w_live}};
  assign sf_rst  = {3{(r_state == S_IDLE) | w_do_rst}};
  assign state_o = r_state;
  assign star_on = r_star_on;
  assign star    = r_star;

  // state, pending command slot and layer mask
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pend  <= 1'b0;
      r_op    <= OP_RUN;
      r_data  <= 3'b000;
      r_mask  <= MASK_RST;
    end else begin
      if (w_accept) begin
        r_pend <= 1'b1;
        r_op   <= op_t'(cmd_op);
        r_data <= cmd_data;
      end else if (w_exec) begin
        r_pend <= 1'b0;
      end
      unique case (r_state)
        S_IDLE: begin
          if (frame_start) r_state <= S_RUN;
        end
        S_RUN, S_PAUSE: begin
          if (w_exec) begin
            unique case (r_op)
              OP_RUN:  r_state <= S_RUN;
              OP_PAU:  r_state <= S_PAUSE;
              OP_RST:  r_state <= S_RUN;
              OP_MASK: r_mask  <= r_data;
              default: r_state <= r_state;
            endcase
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // nearest visible layer wins; farther layers are dimmed
  assign w_cand = sf_on & r_mask & {3{r_state == S_RUN}};

  // priority select of the composite pixel
  always_comb begin
    w_on  = 1'b0;
    w_pix = 8'h00;
    if (w_cand[0]) begin
      w_on  = 1'b1;
      w_pix = sf_star[7:0];
    end else if (w_cand[1]) begin
      w_on  = 1'b1;
      w_pix = sf_star[15:8] >> SHIFT1;
    end else if (w_cand[2]) begin
      w_on  = 1'b1;
      w_pix = sf_star[23:16] >> SHIFT2;
    end
  end

  // composite output register, one clock of latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_star_on <= 1'b0;
      r_star    <= 8'h00;
    end else begin
      r_star_on <= w_on;
      r_star    <= w_pix;
    end
  end

endmodule
